// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and constants for the two-master data-bus arbiter.
//   arb_state_t       : arbiter ownership state (IDLE, OWN0, OWN1)
//   master_id_t       : identifies master 0 (CPU load/store) or master 1 (DMA)
//   DEFAULT_MAX_BURST : default burst bound while the other master waits
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

    // Ownership state that corresponds to a master id.
    function automatic arb_state_t own_state(input master_id_t mid);
        return (mid == MID_M1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Groups both master request ports and the bus-interface-unit side of the
// shared data bus.
//   m0_* / m1_* : req, addr, wdata, we (from masters); gnt, rdata, rvalid (to)
//   daddr, dwdata, dwe : driven towards the bus interface unit
//   drdata             : combinational read data from the bus interface unit
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the bus)
//   master : the environment's view (masters plus bus interface unit)
// -----------------------------------------------------------------------------
interface bus_arbiter_if;

    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_we;
    logic        m0_gnt;
    logic [31:0] m0_rdata;
    logic        m0_rvalid;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_we;
    logic        m1_gnt;
    logic [31:0] m1_rdata;
    logic        m1_rvalid;

    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_we,
        input  m1_req, m1_addr, m1_wdata, m1_we,
        input  drdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output daddr, dwdata, dwe
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_we,
        output m1_req, m1_addr, m1_wdata, m1_we,
        output drdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  daddr, dwdata, dwe
    );

endinterface

// File: rtl/bus_arb_pick.sv
// -----------------------------------------------------------------------------
// bus_arb_pick
// Combinational next-owner selection for bus_arbiter.
//   state      : current ownership state
//   req        : request vector, bit 0 = master 0, bit 1 = master 1
//   last_owner : master most recently granted (round-robin tie-break)
//   at_limit   : owner's burst counter has reached MAX_BURST-1
//   next_state : ownership state for the next cycle
// Build option ARB_ROUND_ROBIN_EN:
//   defined     : IDLE ties go to the master that is not last_owner, and the
//                 burst bound applies to both masters.
//   not defined : fixed priority; master 0 wins ties, preempts master 1 after
//                 its current beat, and is never burst-limited.
// -----------------------------------------------------------------------------
module bus_arb_pick
    import bus_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic [1:0] req,
    input  master_id_t last_owner,
    input  logic       at_limit,
    output arb_state_t next_state
);

    arb_state_t tie_winner;
    logic       yield0;   // OWN0 hands over while both request
    logic       yield1;   // OWN1 hands over while both request

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_winner = own_state(~last_owner);
    assign yield0     = at_limit;
    assign yield1     = at_limit;
`else
    logic unused_pick_inputs;
    assign unused_pick_inputs = at_limit ^ last_owner;

    assign tie_winner = OWN0;
    assign yield0     = 1'b0;
    // Holding OWN1 with m1_req high means this cycle is a beat, so m0 takes
    // over on the closing edge of that beat.
    assign yield1     = 1'b1;
`endif

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req == 2'b11)  next_state = tie_winner;
                else if (req[0])   next_state = OWN0;
                else if (req[1])   next_state = OWN1;
                else               next_state = IDLE;
            end
            OWN0: begin
                if (!req[0])                next_state = req[1] ? OWN1 : IDLE;
                else if (req[1] && yield0)  next_state = OWN1;
            end
            OWN1: begin
                if (!req[1])                next_state = req[0] ? OWN0 : IDLE;
                else if (req[0] && yield1)  next_state = OWN0;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single CPU-side data bus between the CPU load/store port
// (master 0) and the pattern-matching DMA engine (master 1). One owner at a
// time, registered grant, bounded bursts, registered read-data return.
// Parameters:
//   MAX_BURST : beats granted back-to-back to one master while the other
//               requests (1..15)
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : bus_arbiter_if.slave (both masters plus bus interface unit)
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration (see
// bus_arb_pick); the default build is fixed priority to master 0.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
)
(
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t  state;
    arb_state_t  next_state;
    logic [3:0]  burst_cnt;
    master_id_t  last_owner;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_rvalid_q;
    logic        m1_rvalid_q;

    logic beat0;
    logic beat1;
    logic owner_change;
    logic at_limit;

    assign beat0        = bus.m0_req && (state == OWN0);
    assign beat1        = bus.m1_req && (state == OWN1);
    assign owner_change = (next_state != state);
    assign at_limit     = (burst_cnt == BURST_LAST);

    bus_arb_pick u_pick (
        .state      (state),
        .req        ({bus.m1_req, bus.m0_req}),
        .last_owner (last_owner),
        .at_limit   (at_limit),
        .next_state (next_state)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts the owner's beats; any change of state (including dropping to
    // IDLE) starts the count over for whoever owns the bus next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt  <= 4'd0;
            last_owner <= MID_M1;
        end else begin
            if (owner_change)             burst_cnt <= 4'd0;
            else if (beat0 || beat1)      burst_cnt <= burst_cnt + 4'd1;

            if (owner_change && next_state == OWN0) last_owner <= MID_M0;
            if (owner_change && next_state == OWN1) last_owner <= MID_M1;
        end
    end

    // NOTE: the read-data holding registers are plain flops, not a memory,
    // so they are reset to give masters a defined value before the first read.
    // A reset during a read beat clears rvalid, abandoning that beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            m0_rvalid_q <= beat0 && (bus.m0_we == 4'd0);
            m1_rvalid_q <= beat1 && (bus.m1_we == 4'd0);
            if (beat0 && (bus.m0_we == 4'd0)) m0_rdata_q <= bus.drdata;
            if (beat1 && (bus.m1_we == 4'd0)) m1_rdata_q <= bus.drdata;
        end
    end

    // Bus mux: the owner's request gates dwe so the req-drop cycle, which
    // still shows gnt, never writes.
    always_comb begin
        bus.daddr  = 32'd0;
        bus.dwdata = 32'd0;
        bus.dwe    = 4'd0;
        case (state)
            OWN0: begin
                bus.daddr  = bus.m0_addr;
                bus.dwdata = bus.m0_wdata;
                bus.dwe    = bus.m0_we & {4{bus.m0_req}};
            end
            OWN1: begin
                bus.daddr  = bus.m1_addr;
                bus.dwdata = bus.m1_wdata;
                bus.dwe    = bus.m1_we & {4{bus.m1_req}};
            end
            default: ;
        endcase
    end

    assign bus.m0_gnt    = (state == OWN0);
    assign bus.m1_gnt    = (state == OWN1);
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A behavioural model tracks the bus
// owner as a plain integer and is compared against the DUT on every cycle;
// directed sequences add hand-computed expectations. Honours
// ARB_ROUND_ROBIN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int MAX_BURST = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  we    [2];
    logic [31:0] drdata;
    int          left  [2];
    bit          rand_on;

    int checks = 0;
    int errors = 0;

    bus_arbiter_if bif ();

    assign bif.m0_req   = req[0];
    assign bif.m0_addr  = addr[0];
    assign bif.m0_wdata = wdata[0];
    assign bif.m0_we    = we[0];
    assign bif.m1_req   = req[1];
    assign bif.m1_addr  = addr[1];
    assign bif.m1_wdata = wdata[1];
    assign bif.m1_we    = we[1];
    assign bif.drdata   = drdata;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner;     // -1 = nobody, else master index
    int          m_cnt;       // beats by current owner
    int          m_last;      // last master granted
    logic [31:0] m_rdata  [2];
    logic        m_rvalid [2];
    logic        m_beat   [2];  // beat completed at the most recent edge

    always @(posedge clk or negedge reset) begin : model
        int o;
        int y;
        int nxt;
        if (!reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 1;
            for (int i = 0; i < 2; i++) begin
                m_rdata[i]  = 32'd0;
                m_rvalid[i] = 1'b0;
                m_beat[i]   = 1'b0;
            end
        end else begin
            o = m_owner;
            for (int i = 0; i < 2; i++) begin
                m_beat[i]   = (o == i) && req[i];
                m_rvalid[i] = m_beat[i] && (we[i] == 4'd0);
                if (m_rvalid[i]) m_rdata[i] = drdata;
            end
            if (o < 0) begin
                if (req[0] && req[1]) nxt = RR ? ((m_last == 0) ? 1 : 0) : 0;
                else if (req[0])      nxt = 0;
                else if (req[1])      nxt = 1;
                else                  nxt = -1;
            end else begin
                y = 1 - o;
                if (!req[o])
                    nxt = req[y] ? y : -1;
                else if (req[y] && (RR ? ((m_cnt % 16) == MAX_BURST - 1) : (o == 1)))
                    nxt = y;
                else
                    nxt = o;
            end
            if (nxt != o)                    m_cnt = 0;
            else if (o >= 0 && m_beat[o])    m_cnt = m_cnt + 1;
            if (nxt >= 0 && nxt != o)        m_last = nxt;
            m_owner = nxt;
        end
    end

    // ---------------- per-cycle compare + beat log ----------------
    int beat_log[$];

    always @(negedge clk) begin : compare
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  ew;
        ea = 32'd0;
        ed = 32'd0;
        ew = 4'd0;
        if (m_owner >= 0) begin
            ea = addr[m_owner];
            ed = wdata[m_owner];
            ew = req[m_owner] ? we[m_owner] : 4'd0;
        end
        check_b("m0_gnt",    bif.m0_gnt,    m_owner == 0);
        check_b("m1_gnt",    bif.m1_gnt,    m_owner == 1);
        check_b("m0_rvalid", bif.m0_rvalid, m_rvalid[0]);
        check_b("m1_rvalid", bif.m1_rvalid, m_rvalid[1]);
        check("m0_rdata",    bif.m0_rdata,  m_rdata[0]);
        check("m1_rdata",    bif.m1_rdata,  m_rdata[1]);
        check("daddr",       bif.daddr,     ea);
        check("dwdata",      bif.dwdata,    ed);
        check("dwe",         {28'd0, bif.dwe}, {28'd0, ew});
        if (bif.m0_gnt && req[0])      beat_log.push_back(0);
        else if (bif.m1_gnt && req[1]) beat_log.push_back(1);
        else                           beat_log.push_back(9);
    end

    // ---------------- master behaviour ----------------
    task automatic new_txn(input int i);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        we[i]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    endtask

    task automatic drive_masters();
        for (int i = 0; i < 2; i++) begin
            if (req[i] && m_beat[i]) begin
                left[i]--;
                if (left[i] > 0) new_txn(i);
                else             req[i] = 1'b0;
            end
            if (!req[i] && left[i] == 0 && rand_on && $urandom_range(0, 3) == 0) begin
                left[i] = $urandom_range(1, 8);
                new_txn(i);
                req[i] = 1'b1;
            end
        end
    endtask

    // Inputs change 1 time unit after the edge; checks land 2 units after.
    task automatic tick();
        @(posedge clk);
        #1;
        drive_masters();
        #1;
    endtask

    task automatic drain();
        bit busy;
        busy = 1'b1;
        for (int k = 0; k < 200 && busy; k++) begin
            tick();
            busy = req[0] || req[1] || bif.m0_gnt || bif.m1_gnt;
        end
        check_b("drain_to_idle", busy, 1'b0);
    endtask

    int exp_seq [10];

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; we[i] = 4'd0; left[i] = 0;
        end
        drdata  = 32'd0;
        rand_on = 1'b0;

        // Reset values.
        tick();
        tick();
        check_b("rst_m0_gnt",    bif.m0_gnt,    1'b0);
        check_b("rst_m1_gnt",    bif.m1_gnt,    1'b0);
        check_b("rst_m0_rvalid", bif.m0_rvalid, 1'b0);
        check_b("rst_m1_rvalid", bif.m1_rvalid, 1'b0);
        check("rst_m0_rdata",    bif.m0_rdata,  32'd0);
        check("rst_daddr",       bif.daddr,     32'd0);
        check("rst_dwe",         {28'd0, bif.dwe}, 32'd0);
        reset = 1'b1;
        tick();

        // m0 single read: gnt one cycle after req, rvalid one cycle after beat.
        req[0] = 1'b1; addr[0] = 32'h0000_0010; we[0] = 4'd0; left[0] = 1;
        drdata = 32'hDEAD_BEEF;
        tick();
        check_b("rd_gnt_c1",   bif.m0_gnt, 1'b1);
        check("rd_daddr_c1",   bif.daddr,  32'h0000_0010);
        tick();
        check_b("rd_rvalid_c2", bif.m0_rvalid, 1'b1);
        check("rd_rdata_c2",    bif.m0_rdata,  32'hDEAD_BEEF);
        check_b("rd_gnt_drop",  bif.m0_gnt,    1'b1);
        check("rd_dwe_drop",    {28'd0, bif.dwe}, 32'd0);
        tick();
        check_b("rd_rvalid_c3", bif.m0_rvalid, 1'b0);
        check_b("rd_gnt_c3",    bif.m0_gnt,    1'b0);

        // IDLE tie after m0 was the last owner.
        new_txn(0); new_txn(1);
        req[0] = 1'b1; req[1] = 1'b1; left[0] = 1; left[1] = 1;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check_b("rr_tie_m1", bif.m1_gnt, 1'b1);
`else
        check_b("fixed_tie_m0", bif.m0_gnt, 1'b1);
`endif
        drain();

        // m1 single write.
        req[1] = 1'b1; addr[1] = 32'h0080_0000; we[1] = 4'hF; wdata[1] = $urandom; left[1] = 1;
        tick();
        check_b("wr_gnt",      bif.m1_gnt, 1'b1);
        check("wr_dwe_beat",   {28'd0, bif.dwe}, 32'h0000_000F);
        check("wr_daddr",      bif.daddr, 32'h0080_0000);
        tick();
        check("wr_dwe_drop",   {28'd0, bif.dwe}, 32'd0);
        check_b("wr_gnt_drop", bif.m1_gnt,    1'b1);
        check_b("wr_no_rvalid", bif.m1_rvalid, 1'b0);
        tick();
        check_b("wr_gnt_end",   bif.m1_gnt,    1'b0);
        check_b("wr_no_rvalid2", bif.m1_rvalid, 1'b0);

        // m1 burst, m0 joins one cycle later.
        new_txn(1); req[1] = 1'b1; left[1] = 6;
        tick();
        new_txn(0); req[0] = 1'b1; left[0] = 6;
        beat_log.delete();
        repeat (20) tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
`else
        exp_seq = '{1, 0, 0, 0, 0, 0, 0, 9, 1, 1};
`endif
        check("burst_log_len_ok", {31'd0, beat_log.size() >= 10}, 32'd1);
        for (int k = 0; k < 10 && k < beat_log.size(); k++)
            check($sformatf("burst_seq[%0d]", k), beat_log[k], exp_seq[k]);
        drain();

        // Reset asserted during an m0 read beat.
        req[0] = 1'b1; addr[0] = 32'h0000_0020; we[0] = 4'd0; left[0] = 1;
        drdata = $urandom;
        tick();
        reset = 1'b0;
        req[0] = 1'b0; left[0] = 0;
        #1;
        check_b("rst_mid_gnt",    bif.m0_gnt,    1'b0);
        check_b("rst_mid_rvalid", bif.m0_rvalid, 1'b0);
        check("rst_mid_daddr",    bif.daddr,     32'd0);
        check("rst_mid_dwe",      {28'd0, bif.dwe}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_b("post_rst_rvalid1", bif.m0_rvalid, 1'b0);
        tick();
        check_b("post_rst_rvalid2", bif.m0_rvalid, 1'b0);

        // First tie after reset goes to m0 in both builds.
        new_txn(0); new_txn(1);
        req[0] = 1'b1; req[1] = 1'b1; left[0] = 1; left[1] = 1;
        tick();
        check_b("first_tie_m0", bif.m0_gnt, 1'b1);
        check_b("first_tie_m1", bif.m1_gnt, 1'b0);
        drain();

        // Randomised traffic, checked every cycle by the model.
        rand_on = 1'b1;
        repeat (3000) begin
            tick();
            drdata = $urandom;
        end
        rand_on = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
